multicycle_seq_ctrl: RTL and testbench
======================================

// Module: multicycle_seq_ctrl
// PURPOSE
//  Parametrised 5-phase multicycle CPU sequencer (FETCH, DECODE, EXEC, MEM, WB) for the 16-bit SIMPLE ISA.
//  Generalises data width and memory address width, and adds ready/ack memory handshakes with stalls.
//  Adds fixed signed branch conditions, a clean HALT state and a registered OUT strobe.
//  Sits between the instruction/data memories and the board I/O (switches, 7-seg result, phase LEDs).
// PARAMETERS
//  DATA_W  16  register/ALU/data-memory word width; must be >= 16.
//  ADDR_W  16  PC and data-memory address width.
//  NREGS    8  register file depth; fixed by the 3-bit register fields of the encoding.
// PORTS
//  clock        in   1       system clock; all state updates on rising edge.
//  reset        in   1       synchronous, active-high.
//  run_toggle   in   1       1-cycle pulse: start from IDLE, or request stop while running.
//  step         in   1       1-cycle pulse: execute exactly one instruction from IDLE (MC_STEP_EN only).
//  in_data      in   DATA_W  value sampled by IN.
//  imem_req     out  1       fetch request; held until imem_ack.
//  imem_addr    out  ADDR_W  = PC.
//  imem_ack     in   1       imem_rdata valid this cycle.
//  imem_rdata   in   16      instruction word.
//  dmem_req     out  1       data access request; held until dmem_ack.
//  dmem_we      out  1       1 = store, 0 = load.
//  dmem_addr    out  ADDR_W  effective address.
//  dmem_wdata   out  DATA_W  store data.
//  dmem_ack     in   1       access complete; dmem_rdata valid on a load.
//  dmem_rdata   in   DATA_W  load data.
//  out_result   out  DATA_W  last OUT value.
//  out_valid    out  1       1-cycle pulse when out_result updates.
//  phase        out  5       one-hot phase; 5'b00000 in IDLE/HALTED.
//  running      out  1       high in P1..P5.
//  halted       out  1       high in HALTED.
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, PC=0, regs/AR/BR/DR/MDR/IR=0, flags SZCV=0, stop_pend=0.
//  Reset dominates every other input, including mid-phase and mid-handshake; requests drop the next cycle.
//  FSM states: IDLE, P1..P5, HALTED.
//  IDLE -> P1 on run_toggle. run_toggle in P1..P5 sets stop_pend. End of P5: stop_pend ? IDLE (clear) : P1.
//  P1: imem_req=1; stall until imem_ack; then IR<=imem_rdata, PC<=PC+1, go to P2.
//  P2: read operands. ALU class: AR=R[IR10:8], BR=R[IR13:11]; shifts use BR=IR[3:0]; IN uses BR=in_data.
//      Load/store: AR=R[IR10:8], BR=sext(IR7:0). Branch: AR=PC (already +1), BR=sext(IR7:0).
//  P3: DR<=ALU(AR,BR); add for load/store/branch. OUT: out_result<=AR, out_valid pulse. HALT -> HALTED.
//  P4: load/store only: dmem_req=1, dmem_addr=DR[ADDR_W-1:0]; stall until dmem_ack.
//      Store writes R[IR13:11]; load gives MDR<=dmem_rdata. Other classes pass P4 in 1 cycle.
//  P5 writeback: ALU ops except CMP/OUT write R[IR10:8]<=DR. Load: R[IR13:11]<=MDR.
//      LI: R[IR10:8]<=sext(IR7:0). Flags commit here for ALU ops.
//  Branch rules: B always. BE Z. BLT S^V. BLE Z|(S^V). BNE !Z. Taken: PC<=DR.
//      Flags used are those before this P5 commit.
//  Arithmetic: all DATA_W wide, wraps modulo 2^DATA_W. C/V from ADD/SUB/CMP; logic ops clear C,V.
//      Shifts set C = last bit shifted out.
//  PC wraps 2^ADDR_W-1 -> 0.
//  Simultaneous run_toggle+step: run_toggle wins. Handshakes: ack without req is ignored.
//  HALTED: only reset leaves it.
// CONFIGURATION
//  MC_STEP_EN defined: step in IDLE runs P1..P5 once, then returns to IDLE.
//  MC_STEP_EN undefined: step is ignored and no step logic is built.
// STRUCTURE
//  Package mc_pkg holds: opcode class codes, ALU op localparams (ADD..HALT), branch cond codes, phase_e one-hot enum.
//  Sub-module mc_alu #(DATA_W) is combinational: op, a, b -> y, {V,C,Z,S}, flag_we.
// TESTING
//  Program LI r1,5; LI r2,3; ADD r1,r2; OUT r1; HALT -> out_result=8, out_valid 1 cycle, halted=1.
//  imem_ack delayed 3 cycles on every fetch -> phase holds P1 for 4 cycles; final results unchanged.
//  Store r1=0x1234 to [r0+4], then load into r3 with dmem_ack latency 2 -> r3=0x1234, dmem_we=1 only on the store.
//  CMP r1=2 with r2=5; BLT +2 -> branch taken (S^V=1). Repeat with r1=5 -> not taken.
//  run_toggle in P3 -> completes P5 then IDLE with PC advanced. reset asserted in P4 -> next cycle all outputs 0.
//  MC_STEP_EN: step from IDLE -> exactly 5 phase states, PC+1, IDLE again; undefined -> state stays IDLE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle SIMPLE sequencer: instruction class
// codes, ALU operation codes, branch conditions, phase and state encodings.
package mc_pkg;

  // Instruction class, IR[15:14]
  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  // ALU operation codes, IR[7:4] of the ALU class
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_CMP  = 4'h5;
  localparam logic [3:0] ALU_MOV  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLR  = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hB;
  localparam logic [3:0] ALU_IN   = 4'hC;
  localparam logic [3:0] ALU_OUT  = 4'hD;
  localparam logic [3:0] ALU_HALT = 4'hF;

  // Sub-opcode of the immediate/branch class, IR[13:11]
  localparam logic [2:0] OP2_LI  = 3'b000;
  localparam logic [2:0] OP2_B   = 3'b100;
  localparam logic [2:0] OP2_BCC = 3'b111;

  // Conditional branch codes, IR[10:8]
  localparam logic [2:0] BC_BE  = 3'd0;
  localparam logic [2:0] BC_BLT = 3'd1;
  localparam logic [2:0] BC_BLE = 3'd2;
  localparam logic [2:0] BC_BNE = 3'd3;

  // Bit positions inside the {V,C,Z,S} flag vector
  localparam int FLG_S = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [4:0] {
    PH_NONE   = 5'b00000,
    PH_FETCH  = 5'b00001,
    PH_DECODE = 5'b00010,
    PH_EXEC   = 5'b00100,
    PH_MEM    = 5'b01000,
    PH_WB     = 5'b10000
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_HALTED
  } state_e;

  // Shift/rotate group shares the 4'b10xx code space
  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the SIMPLE sequencer. Produces result, {V,C,Z,S}
// and whether the operation is allowed to update the flag register.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags,
  output logic              flag_we
);

  localparam int M = DATA_W - 1;

  logic [3:0]          sh;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     shl;
  logic [DATA_W:0]     shr;
  logic [DATA_W:0]     sra_w;
  logic [2*DATA_W-1:0] rot;
  logic                c;
  logic                v;

  // Shift amount comes from the 4-bit immediate placed in b
  assign sh    = b[3:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // Top bit of diff is the borrow
  assign diff  = {1'b0, a} - {1'b0, b};
  // Extra bit above/below the word catches the last bit shifted out
  assign shl   = {1'b0, a} << sh;
  assign shr   = {a, 1'b0} >> sh;
  assign sra_w = $signed({a, 1'b0}) >>> sh;
  assign rot   = {a, a} << sh;

  // Operation select and flag generation
  always_comb begin
    y       = a;
    c       = 1'b0;
    v       = 1'b0;
    flag_we = 1'b0;
    case (op)
      ALU_ADD: begin
        y = sum[M:0]; c = sum[DATA_W];
        v = (a[M] == b[M]) && (sum[M] != a[M]); flag_we = 1'b1;
      end
      ALU_SUB, ALU_CMP: begin
        y = diff[M:0]; c = diff[DATA_W];
        v = (a[M] != b[M]) && (diff[M] != a[M]); flag_we = 1'b1;
      end
      ALU_AND: begin y = a & b; flag_we = 1'b1; end
      ALU_OR:  begin y = a | b; flag_we = 1'b1; end
      ALU_XOR: begin y = a ^ b; flag_we = 1'b1; end
      ALU_MOV: begin y = b;     flag_we = 1'b1; end
      ALU_SLL: begin y = shl[M:0]; c = shl[DATA_W]; flag_we = 1'b1; end
      ALU_SLR: begin
        y = rot[2*DATA_W-1:DATA_W];
        c = (sh != 4'd0) && rot[DATA_W];
        flag_we = 1'b1;
      end
      ALU_SRL: begin y = shr[DATA_W:1];   c = shr[0];   flag_we = 1'b1; end
      ALU_SRA: begin y = sra_w[DATA_W:1]; c = sra_w[0]; flag_we = 1'b1; end
      ALU_IN:  y = b;
      default: y = a;
    endcase
    flags = {v, c, (y == '0), y[M]};
  end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Five-phase multicycle sequencer for the 16-bit SIMPLE ISA with
// ready/ack instruction and data memory handshakes.
// Optional build macro MC_STEP_EN enables single-instruction stepping.
module multicycle_seq_ctrl
  import mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_toggle,
  input  logic              step,
  input  logic [DATA_W-1:0] in_data,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] out_result,
  output logic              out_valid,
  output logic [4:0]        phase,
  output logic              running,
  output logic              halted
);

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] ar, br, dr, mdr;
  logic [3:0]        szcv;
  logic [3:0]        szcv_dr;
  logic              flag_we_dr;
  logic              stop_pend;
  logic [DATA_W-1:0] regs [NREGS];

  logic [1:0]        cls;
  logic [2:0]        op2, ra_idx, rd_idx;
  logic [3:0]        op3, alu_op;
  logic [DATA_W-1:0] imm_sext, pc_ext, alu_y;
  logic [3:0]        alu_flags;
  logic              alu_flag_we, is_mem, br_taken, stop_now, lt;

`ifndef MC_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  assign imem_addr = pc;
  assign cls       = ir[15:14];
  assign op2       = ir[13:11];
  assign ra_idx    = ir[13:11];
  assign rd_idx    = ir[10:8];
  assign op3       = ir[7:4];
  assign imm_sext  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign pc_ext    = DATA_W'(pc);
  assign is_mem    = (cls == CLS_LD) || (cls == CLS_ST);
  // Address and branch-target arithmetic reuse the ALU adder
  assign alu_op    = (cls == CLS_ALU) ? op3 : ALU_ADD;
  // A toggle arriving during the final phase still stops this instruction
  assign stop_now  = stop_pend | run_toggle;
  assign lt        = szcv[FLG_S] ^ szcv[FLG_V];

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (alu_op),
    .a       (ar),
    .b       (br),
    .y       (alu_y),
    .flags   (alu_flags),
    .flag_we (alu_flag_we)
  );

  // Branch decision from the flags committed by earlier instructions
  always_comb begin
    br_taken = 1'b0;
    if (cls == CLS_IMM) begin
      if (op2 == OP2_B) begin
        br_taken = 1'b1;
      end else if (op2 == OP2_BCC) begin
        case (ir[10:8])
          BC_BE:   br_taken = szcv[FLG_Z];
          BC_BLT:  br_taken = lt;
          BC_BLE:  br_taken = szcv[FLG_Z] | lt;
          BC_BNE:  br_taken = ~szcv[FLG_Z];
          default: br_taken = 1'b0;
        endcase
      end
    end
  end

  // Phase sequencer, datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= PH_NONE;
      running    <= 1'b0;
      halted     <= 1'b0;
      pc         <= '0;
      ir         <= '0;
      ar         <= '0;
      br         <= '0;
      dr         <= '0;
      mdr        <= '0;
      szcv       <= '0;
      szcv_dr    <= '0;
      flag_we_dr <= 1'b0;
      stop_pend  <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (run_toggle && running) stop_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (run_toggle) begin
            state <= ST_P1; phase <= PH_FETCH; running <= 1'b1;
            imem_req <= 1'b1; stop_pend <= 1'b0;
          end
`ifdef MC_STEP_EN
          else if (step) begin
            state <= ST_P1; phase <= PH_FETCH; running <= 1'b1;
            imem_req <= 1'b1; stop_pend <= 1'b1;
          end
`endif
        end
        ST_P1: begin
          if (imem_req && imem_ack) begin
            ir <= imem_rdata; pc <= pc + 1'b1; imem_req <= 1'b0;
            state <= ST_P2; phase <= PH_DECODE;
          end
        end
        ST_P2: begin
          ar <= regs[rd_idx];
          br <= imm_sext;
          if (cls == CLS_ALU) begin
            if (is_shift(op3))     br <= DATA_W'(ir[3:0]);
            else if (op3 == ALU_IN) br <= in_data;
            else                    br <= regs[ra_idx];
          end else if (cls == CLS_IMM) begin
            ar <= pc_ext;
          end
          state <= ST_P3; phase <= PH_EXEC;
        end
        ST_P3: begin
          dr <= alu_y; szcv_dr <= alu_flags; flag_we_dr <= alu_flag_we;
          if (cls == CLS_ALU && op3 == ALU_HALT) begin
            state <= ST_HALTED; phase <= PH_NONE;
            running <= 1'b0; halted <= 1'b1;
          end else begin
            if (cls == CLS_ALU && op3 == ALU_OUT) begin
              out_result <= ar; out_valid <= 1'b1;
            end
            if (is_mem) begin
              dmem_req   <= 1'b1;
              dmem_we    <= (cls == CLS_ST);
              dmem_addr  <= ADDR_W'(alu_y);
              dmem_wdata <= regs[ra_idx];
            end
            state <= ST_P4; phase <= PH_MEM;
          end
        end
        ST_P4: begin
          if (!is_mem) begin
            state <= ST_P5; phase <= PH_WB;
          end else if (dmem_req && dmem_ack) begin
            if (!dmem_we) mdr <= dmem_rdata;
            dmem_req <= 1'b0; dmem_we <= 1'b0;
            state <= ST_P5; phase <= PH_WB;
          end
        end
        ST_P5: begin
          if (cls == CLS_ALU) begin
            if (op3 != ALU_CMP && op3 != ALU_OUT) regs[rd_idx] <= dr;
            if (flag_we_dr) szcv <= szcv_dr;
          end else if (cls == CLS_LD) begin
            regs[ra_idx] <= mdr;
          end else if (cls == CLS_IMM) begin
            if (op2 == OP2_LI) regs[rd_idx] <= imm_sext;
            if (br_taken)      pc <= ADDR_W'(dr);
          end
          if (stop_now) begin
            state <= ST_IDLE; phase <= PH_NONE;
            running <= 1'b0; stop_pend <= 1'b0;
          end else begin
            state <= ST_P1; phase <= PH_FETCH; imem_req <= 1'b1;
          end
        end
        ST_HALTED: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed self-checking bench for multicycle_seq_ctrl (MC_STEP_EN aware).
module tb_multicycle_seq_ctrl;

  localparam logic [4:0] P_IDLE = 5'b00000;
  localparam logic [4:0] P_F    = 5'b00001;
  localparam logic [4:0] P_D    = 5'b00010;
  localparam logic [4:0] P_E    = 5'b00100;
  localparam logic [4:0] P_M    = 5'b01000;
  localparam logic [4:0] P_W    = 5'b10000;

  logic        clock = 1'b0, reset = 1'b1, run_toggle = 1'b0, step = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        out_valid, running, halted;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, out_result;
  logic [4:0]  phase;

  logic [15:0] rom  [0:63];
  logic [15:0] dram [0:255];
  int imem_lat = 0, dmem_lat = 0, icnt = 0, dcnt = 0;
  int ov_cnt = 0, st_cyc = 0, ld_cyc = 0;
  logic [15:0] st_addr = 16'h0, st_data = 16'h0;
  int tests = 0, fails = 0;

  multicycle_seq_ctrl #(.DATA_W(16), .ADDR_W(16), .NREGS(8)) dut (
    .clock(clock), .reset(reset), .run_toggle(run_toggle), .step(step),
    .in_data(in_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_result(out_result),
    .out_valid(out_valid), .phase(phase), .running(running), .halted(halted)
  );

  always #5 clock = ~clock;

  // Memory responders: ack after a programmable number of waiting cycles
  assign imem_ack   = imem_req && (icnt >= imem_lat);
  assign imem_rdata = rom[imem_addr[5:0]];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_lat);
  assign dmem_rdata = dram[dmem_addr[7:0]];

  always @(posedge clock) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      dram[dmem_addr[7:0]] <= dmem_wdata;
      st_addr <= dmem_addr;
      st_data <= dmem_wdata;
    end
  end

  always @(negedge clock) begin
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (dmem_req && dmem_we) st_cyc <= st_cyc + 1;
    if (dmem_req && !dmem_we) ld_cyc <= ld_cyc + 1;
  end

  function automatic logic [15:0] e_alu(input logic [2:0] rs, input logic [2:0] rd,
                                        input logic [3:0] op, input logic [3:0] d);
    return {2'b11, rs, rd, op, d};
  endfunction
  function automatic logic [15:0] e_li(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b10, 3'b000, rd, imm};
  endfunction
  function automatic logic [15:0] e_mem(input logic st, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [7:0] d);
    return {1'b0, st, ra, rb, d};
  endfunction

  localparam logic [15:0] HALT = 16'hC0F0;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic start();
    run_toggle = 1'b1; tick(); run_toggle = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = HALT;
  endtask

  task automatic wait_halt(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin tick(); cyc++; end
    tests++;
    if (!halted) begin fails++; $display("FAIL %s_halt got=timeout exp=halted", name); end
  endtask

  task automatic load_add_prog();
    clear_rom();
    rom[0] = e_li(3'd1, 8'h05);
    rom[1] = e_li(3'd2, 8'h03);
    rom[2] = e_alu(3'd2, 3'd1, 4'h0, 4'h0);
    rom[3] = e_alu(3'd0, 3'd1, 4'hD, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    tests++; if (phase !== P_IDLE) begin fails++; $display("FAIL rst_phase got=%b exp=%b", phase, P_IDLE); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    tests++; if (imem_addr !== 16'h0) begin fails++; $display("FAIL rst_pc got=%h exp=0000", imem_addr); end
    tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin fails++; $display("FAIL rst_dmem got=%b%b exp=00", dmem_req, dmem_we); end
    tests++; if (out_result !== 16'h0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_out got=%h/%b exp=0000/0", out_result, out_valid); end
    tests++; if (running !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL rst_status got=%b%b exp=00", running, halted); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, ov0;
    load_add_prog(); imem_lat = 0; dmem_lat = 0;
    do_reset(); ov0 = ov_cnt; start();
    tests++; if (phase !== P_F || running !== 1'b1) begin fails++; $display("FAIL basic_start got=%b/%b exp=%b/1", phase, running, P_F); end
    wait_halt("basic", 200, cyc);
    tests++; if (cyc != 23) begin fails++; $display("FAIL basic_cycles got=%0d exp=23", cyc); end
    tests++; if (out_result !== 16'h0008) begin fails++; $display("FAIL basic_out got=%h exp=0008", out_result); end
    tests++; if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL basic_valid_pulses got=%0d exp=1", ov_cnt - ov0); end
    tests++; if (phase !== P_IDLE || running !== 1'b0) begin fails++; $display("FAIL basic_halt_state got=%b/%b exp=%b/0", phase, running, P_IDLE); end
    tests++; if (imem_addr !== 16'h0005) begin fails++; $display("FAIL basic_pc got=%h exp=0005", imem_addr); end
    repeat (3) tick();
    tests++; if (halted !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL basic_stay_halted got=%b/%b exp=1/0", halted, imem_req); end
  endtask

  task automatic test_imem_stall();
    int cyc, n, ov0;
    load_add_prog(); imem_lat = 3; dmem_lat = 0;
    do_reset(); ov0 = ov_cnt; start();
    n = 0;
    while (phase === P_F && n < 20) begin tick(); n++; end
    tests++; if (n != 4) begin fails++; $display("FAIL stall_p1_hold got=%0d exp=4", n); end
    tests++; if (phase !== P_D) begin fails++; $display("FAIL stall_next_phase got=%b exp=%b", phase, P_D); end
    wait_halt("stall", 400, cyc);
    tests++; if (n + cyc != 38) begin fails++; $display("FAIL stall_cycles got=%0d exp=38", n + cyc); end
    tests++; if (out_result !== 16'h0008 || ov_cnt - ov0 != 1) begin fails++; $display("FAIL stall_out got=%h/%0d exp=0008/1", out_result, ov_cnt - ov0); end
    imem_lat = 0;
  endtask

  task automatic test_mem();
    int cyc, ov0, s0, l0;
    clear_rom();
    rom[0] = e_li(3'd1, 8'h12);
    rom[1] = e_alu(3'd0, 3'd1, 4'h8, 4'h8);
    rom[2] = e_li(3'd2, 8'h34);
    rom[3] = e_alu(3'd2, 3'd1, 4'h3, 4'h0);
    rom[4] = e_mem(1'b1, 3'd1, 3'd0, 8'h04);
    rom[5] = e_mem(1'b0, 3'd3, 3'd0, 8'h04);
    rom[6] = e_alu(3'd0, 3'd3, 4'hD, 4'h0);
    imem_lat = 0; dmem_lat = 2;
    do_reset(); ov0 = ov_cnt; s0 = st_cyc; l0 = ld_cyc; start();
    wait_halt("mem", 400, cyc);
    tests++; if (out_result !== 16'h1234) begin fails++; $display("FAIL mem_load_value got=%h exp=1234", out_result); end
    tests++; if (st_addr !== 16'h0004 || st_data !== 16'h1234) begin fails++; $display("FAIL mem_store got=%h@%h exp=1234@0004", st_data, st_addr); end
    tests++; if (st_cyc - s0 != 3) begin fails++; $display("FAIL mem_we_cycles got=%0d exp=3", st_cyc - s0); end
    tests++; if (ld_cyc - l0 != 3) begin fails++; $display("FAIL mem_load_cycles got=%0d exp=3", ld_cyc - l0); end
    tests++; if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL mem_valid_pulses got=%0d exp=1", ov_cnt - ov0); end
    tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin fails++; $display("FAIL mem_idle_bus got=%b%b exp=00", dmem_req, dmem_we); end
    dmem_lat = 0;
  endtask

  task automatic test_branch(input logic [7:0] r1v, input logic [15:0] exp_out, input string name);
    int cyc, ov0;
    clear_rom();
    rom[0] = e_li(3'd1, r1v);
    rom[1] = e_li(3'd2, 8'h05);
    rom[2] = e_alu(3'd2, 3'd1, 4'h5, 4'h0);
    rom[3] = {2'b10, 3'b111, 3'd1, 8'h02};
    rom[4] = e_li(3'd4, 8'h4E);
    rom[5] = {2'b10, 3'b100, 3'd0, 8'h01};
    rom[6] = e_li(3'd4, 8'h7A);
    rom[7] = e_alu(3'd0, 3'd4, 4'hD, 4'h0);
    do_reset(); ov0 = ov_cnt; start();
    wait_halt(name, 400, cyc);
    tests++; if (out_result !== exp_out) begin fails++; $display("FAIL %s_out got=%h exp=%h", name, out_result, exp_out); end
    tests++; if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL %s_pulses got=%0d exp=1", name, ov_cnt - ov0); end
  endtask

  task automatic test_run_stop();
    int n;
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = e_li(3'd1, 8'h01);
    do_reset(); start();
    n = 0;
    while (phase !== P_E && n < 20) begin tick(); n++; end
    tests++; if (phase !== P_E) begin fails++; $display("FAIL stop_reach_p3 got=%b exp=%b", phase, P_E); end
    run_toggle = 1'b1; tick(); run_toggle = 1'b0;
    tests++; if (phase !== P_M) begin fails++; $display("FAIL stop_p4 got=%b exp=%b", phase, P_M); end
    tick();
    tests++; if (phase !== P_W) begin fails++; $display("FAIL stop_p5 got=%b exp=%b", phase, P_W); end
    tick();
    tests++; if (phase !== P_IDLE || running !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL stop_idle got=%b/%b%b exp=%b/00", phase, running, halted, P_IDLE); end
    tests++; if (imem_addr !== 16'h0001) begin fails++; $display("FAIL stop_pc got=%h exp=0001", imem_addr); end
    repeat (3) tick();
    tests++; if (phase !== P_IDLE || imem_req !== 1'b0) begin fails++; $display("FAIL stop_stays_idle got=%b/%b exp=%b/0", phase, imem_req, P_IDLE); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_rom();
    rom[0] = e_li(3'd1, 8'h55);
    rom[1] = e_alu(3'd0, 3'd1, 4'hD, 4'h0);
    rom[2] = e_mem(1'b1, 3'd1, 3'd0, 8'h04);
    dmem_lat = 8;
    do_reset(); start();
    n = 0;
    while (!(phase === P_M && dmem_req === 1'b1) && n < 60) begin tick(); n++; end
    tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 16'h0055) begin fails++; $display("FAIL rmid_in_store got=%b%b/%h exp=11/0055", dmem_req, dmem_we, dmem_wdata); end
    tests++; if (out_result !== 16'h0055) begin fails++; $display("FAIL rmid_out_before got=%h exp=0055", out_result); end
    reset = 1'b1; tick();
    tests++; if (phase !== P_IDLE || running !== 1'b0) begin fails++; $display("FAIL rmid_phase got=%b/%b exp=%b/0", phase, running, P_IDLE); end
    tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin fails++; $display("FAIL rmid_dmem got=%b%b exp=00", dmem_req, dmem_we); end
    tests++; if (dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin fails++; $display("FAIL rmid_dbus got=%h/%h exp=0000/0000", dmem_addr, dmem_wdata); end
    tests++; if (out_result !== 16'h0 || imem_addr !== 16'h0 || imem_req !== 1'b0) begin fails++; $display("FAIL rmid_misc got=%h/%h/%b exp=0000/0000/0", out_result, imem_addr, imem_req); end
    reset = 1'b0; dmem_lat = 0;
  endtask

  task automatic test_step();
    logic [4:0] seq [6];
    seq[0] = P_F; seq[1] = P_D; seq[2] = P_E; seq[3] = P_M; seq[4] = P_W; seq[5] = P_IDLE;
    clear_rom();
    for (int i = 0; i < 20; i++) rom[i] = e_li(3'd1, 8'h01);
    do_reset();
    step = 1'b1; tick(); step = 1'b0;
`ifdef MC_STEP_EN
    for (int i = 0; i < 6; i++) begin
      tests++; if (phase !== seq[i]) begin fails++; $display("FAIL step_phase%0d got=%b exp=%b", i, phase, seq[i]); end
      tick();
    end
    tests++; if (imem_addr !== 16'h0001 || running !== 1'b0) begin fails++; $display("FAIL step_end got=%h/%b exp=0001/0", imem_addr, running); end
`else
    for (int i = 0; i < 6; i++) begin
      tests++; if (phase !== P_IDLE || imem_req !== 1'b0) begin fails++; $display("FAIL step_ignored%0d got=%b/%b exp=%b/0 (seq %b)", i, phase, imem_req, P_IDLE, seq[i]); end
      tick();
    end
    tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL step_pc got=%h exp=0000", imem_addr); end
`endif
    do_reset();
    run_toggle = 1'b1; step = 1'b1; tick(); run_toggle = 1'b0; step = 1'b0;
    repeat (10) tick();
    tests++; if (running !== 1'b1 || phase === P_IDLE) begin fails++; $display("FAIL run_beats_step got=%b/%b exp=1/nonzero", running, phase); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imem_stall();
    test_mem();
    test_branch(8'h02, 16'h007A, "blt_taken");
    test_branch(8'h05, 16'h004E, "blt_not_taken");
    test_branch(8'hFF, 16'h007A, "blt_negative");
    test_run_stop();
    test_reset_mid();
    test_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
